// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd tile processor
// and its output packer.
package winograd_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LINE_WIDTH = 512;

  // Word lanes holding y00, y01, y10, y11 of a 2x2 result tile
  localparam logic [3:0][3:0] TILE_LANES = {4'd5, 4'd4, 4'd1, 4'd0};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } pack_state_t;

endpackage

// File: rtl/winograd_output_packer.sv
// Drains 2x2 result tiles from the processor FIFO and packs four
// tiles per dense write-back line, zero-padding the last line.
module winograd_output_packer
  import winograd_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TILES_PER_LINE = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              ctx_length,
  input  logic [16*DATA_WIDTH-1:0] tile_fifo_dout,
  input  logic                     tile_fifo_empty,
  output logic                     tile_fifo_re,
  output logic [16*DATA_WIDTH-1:0] line_data,
  output logic                     line_valid,
  input  logic                     line_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = 16 * DATA_WIDTH;
  localparam int SW = LW / TILES_PER_LINE;
  localparam logic [2:0] FULL = 3'(TILES_PER_LINE);

  pack_state_t state, state_n;

  logic [31:0]   remaining_req;
  logic [31:0]   remaining_rx;
  logic [31:0]   rx_nxt;
  logic [2:0]    pack_count;
  logic [2:0]    pc_nxt;
  logic          inflight;
  logic [LW-1:0] pack;
  logic [LW-1:0] pack_nxt;
  logic          out_free;
  logic          xfer;
  logic          fin;
  logic          unused_lanes;

  assign unused_lanes = ^tile_fifo_dout;

  assign out_free = !line_valid || line_ready;
  assign pc_nxt   = pack_count + {2'b0, inflight};
  assign rx_nxt   = remaining_rx - {31'b0, inflight};
  assign fin      = remaining_rx == '0 && pack_count == '0
                    && line_valid && line_ready;

  // Arriving tile is merged combinationally so a completing
  // tile can go straight to the output register.
  always_comb begin
    pack_nxt = pack;
    for (int s = 0; s < 4; s++) begin
      if (inflight && pack_count == 3'(s)) begin
        for (int j = 0; j < 4; j++) begin
          pack_nxt[SW*s + DATA_WIDTH*j +: DATA_WIDTH] =
            tile_fifo_dout[DATA_WIDTH*TILE_LANES[j] +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    tile_fifo_re = 1'b0;
    xfer         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = (ctx_length == '0) ? DONE : RUN;
      end
      RUN: begin
        tile_fifo_re = !tile_fifo_empty
                       && remaining_req != '0
                       && (pack_count + {2'b0, inflight}) < FULL;
        xfer = pc_nxt == FULL && out_free;
        if (fin)
          state_n = DONE;
        else if (rx_nxt == '0 && pc_nxt != '0 && pc_nxt != FULL)
          state_n = FLUSH;
      end
      FLUSH: begin
        xfer = pack_count != '0 && out_free;
        if (fin) state_n = DONE;
      end
      DONE: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_req <= '0;
      remaining_rx  <= '0;
      pack_count    <= '0;
      inflight      <= 1'b0;
      pack          <= '0;
      line_data     <= '0;
      line_valid    <= 1'b0;
    end else begin
      inflight <= tile_fifo_re;
      if (tile_fifo_re) remaining_req <= remaining_req - 32'd1;
      if (inflight)     remaining_rx  <= rx_nxt;
      if (xfer) begin
        line_data  <= pack_nxt;
        line_valid <= 1'b1;
        pack       <= '0;
        pack_count <= '0;
      end else begin
        pack       <= pack_nxt;
        pack_count <= pc_nxt;
        if (line_ready) line_valid <= 1'b0;
      end
      if (state == IDLE && start && ctx_length != '0) begin
        remaining_req <= ctx_length;
        remaining_rx  <= ctx_length;
        pack_count    <= '0;
        pack          <= '0;
      end
    end
  end

  assign busy = state == RUN || state == FLUSH;
  assign done = state == DONE;

endmodule

// File: doc/winograd_output_packer.md
# winograd_output_packer

Downstream stage of the Winograd tile processor. Drains the processor's output FIFO, which holds one 2x2 result tile per 512-bit line in word lanes 0, 1, 4 and 5. Packs four tiles into each dense 512-bit write-back line. Presents the packed lines on a valid/ready port to the AFU write path, zero-pads the final partial line, and pulses done when the job's tile count has been written.

## Interface
- DATA_WIDTH, 32, width of one result element; line is 16 x DATA_WIDTH = 512 bits
- TILES_PER_LINE, 4, tiles packed per output line (fixed at 4; other values unsupported)

- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse: begin job, latch ctx_length
- ctx_length  in  32  number of 2x2 tiles in the job, sampled on start
- tile_fifo_dout  in  512  upstream FIFO data; valid the cycle after tile_fifo_re
- tile_fifo_empty  in  1  upstream FIFO empty
- tile_fifo_re  out  1  upstream FIFO read enable
- line_data  out  512  packed line
- line_valid  out  1  line_data valid
- line_ready  in  1  write path accepts line when line_valid & line_ready
- busy  out  1  high in RUN/FLUSH
- done  out  1  one-cycle pulse when job complete

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start with ctx_length > 0 → RUN. Latches remaining_req = remaining_rx = ctx_length and clears pack_count. start with ctx_length == 0 → DONE directly. start outside IDLE is ignored.
- RUN: tile_fifo_re = !tile_fifo_empty & remaining_req != 0 & (pack_count + inflight < 4).
  - inflight is a 1-bit register equal to the previous cycle's tile_fifo_re.
  - Each re decrements remaining_req.
- Arriving tile (inflight=1): words 0, 1, 4, 5 of tile_fifo_dout go to pack slot pack_count, at bits 128*pack_count +: 128, in order y00, y01, y10, y11. Then pack_count increments and remaining_rx decrements.
- Transfer: pack_count==4 and output register free (!line_valid | line_ready) → line_data = pack, line_valid=1, pack_count=0.
- Partial line: remaining_rx reaches 0 with 0 < pack_count < 4 → FLUSH. FLUSH transfers the pack with unused slots zero, on the same free-register rule.
- When remaining_rx==0, pack_count==0 and the final line is accepted → DONE. DONE pulses done for 1 cycle, then → IDLE.
- Upstream words 2, 3 and 6-15 are ignored.
- Arithmetic: counters are 32-bit unsigned; pack_count is 3 bits and saturates at 4 by construction.

## Timing
- Reset values: tile_fifo_re=0, line_valid=0, line_data=0, busy=0, done=0, state IDLE, all counters 0.
- Read latency: a tile is read at cycle t (re=1), captured into the pack at t+1, and can reach line_valid at t+2 at earliest.
- Steady state with upstream never empty and line_ready=1: one line every 5 cycles.
- line_data and line_valid are held stable while line_valid & !line_ready. line_valid is never dropped without acceptance.
- A transfer and an acceptance in the same cycle reload the output register back-to-back.
- tile_fifo_re is never asserted when tile_fifo_empty=1 or when remaining_req=0.
- Reset asserted mid-job: all outputs return to reset values immediately and asynchronously. A pending line is discarded and done is not pulsed.

## Structure
- Shared package winograd_pkg: DATA_WIDTH, LINE_WIDTH=512, TILE_LANES constant {0,1,4,5}, and the state enum type pack_state_t. The processor and this block both use these lane constants.
- No sub-module. One module holding the FSM, counters, pack register and output register.

## Test plan
- ctx_length=4, upstream tiles k=0..3 with words {k*4+0, k*4+1, k*4+2, k*4+3} in lanes 0, 1, 4, 5, line_ready=1 → one line with words 0..15 = 0,1,...,15 in order, then a done pulse one cycle after acceptance.
- ctx_length=6 → line 1 holds tiles 0-3. Line 2 holds tiles 4-5 with words 8-15 zero. done pulses after line 2. Exactly 6 re pulses.
- ctx_length=8 with line_ready held low for 20 cycles after the first line_valid → line 1 is stable throughout. re stops once pack_count+inflight reaches 4. No tile is lost or duplicated. Both lines are correct after release.
- tile_fifo_empty toggling randomly on a 50% pattern, ctx_length=12 → re is never asserted while empty. Output is 3 correct lines.
- start with ctx_length=0 → no re, no line_valid, done pulses 1 cycle later.
- Reset asserted while line_valid=1 and pack_count=2 → line_valid, busy and re are 0 immediately. A subsequent start with ctx_length=4 produces one correct line.
